// File: rtl/sram_stream_reader.sv
// Streams a contiguous SRAM address range out as a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle SRAM read latency, and issue is credit-gated so the FIFO cannot overflow.
module sram_stream_reader #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 11
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] addr;
    logic [AW-1:0] last_a;
    logic [CW-1:0] rem_issue;
    logic [CW-1:0] rem_pop;
    logic          inflight;

    logic [DW-1:0] fifo0;
    logic [DW-1:0] fifo1;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;

    logic          pop;
    logic          push;
    logic          issue;
    logic          accept;
    logic [2:0]    credit_use;

    assign sram_wen  = 1'b1;
    assign out_valid = (count != 2'd0);
    assign out_data  = rd_ptr ? fifo1 : fifo0;
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign accept    = (state == S_IDLE) && start;

    // Words committed to the FIFO once this cycle's pop is taken into account.
    assign credit_use = 3'(count) + 3'(inflight) - 3'(pop);

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and combinational SRAM/handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        issue    = 1'b0;
        sram_cen = 1'b1;
        sram_a   = last_a;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len == CW'(0)) ? S_ZERO : S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                issue = (rem_issue != CW'(0)) && (credit_use < 3'd2);
                if (issue) begin
                    sram_cen = 1'b0;
                    sram_a   = addr;
                end
                if (pop && (rem_pop == CW'(1))) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_ZERO: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Job counters and address walk
    always_ff @(posedge CLK) begin
        if (reset) begin
            addr      <= '0;
            last_a    <= '0;
            rem_issue <= '0;
            rem_pop   <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                addr      <= base_addr;
                rem_issue <= len;
                rem_pop   <= len;
            end
            if (issue) begin
                addr      <= addr + AW'(1);
                last_a    <= addr;
                rem_issue <= rem_issue - CW'(1);
            end
            if (pop) begin
                rem_pop <= rem_pop - CW'(1);
            end
        end
    end

    // Two-entry return FIFO; the SRAM word lands here the cycle after its read edge
    always_ff @(posedge CLK) begin
        if (reset) begin
            fifo0  <= '0;
            fifo1  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    fifo1 <= sram_q;
                end else begin
                    fifo0 <= sram_q;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench for sram_stream_reader against a count-based reference model of the stream reader.
module tb_sram_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 11;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [DEPTH];
    int ready_mode = 0;
    int pidx = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    sram_stream_reader #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_q(sram_q), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    // SRAM macro behaviour: Q valid after the read edge
    always @(posedge CLK) if (!sram_cen) sram_q <= mem[sram_a];

    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pidx % 6]; pidx++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word issued in cycle t is poppable from cycle t+2
    int cyc = 0;
    bit run_m = 0, zero_m = 0, busy_m = 0;
    int base_m = 0, len_m = 0, issued = 0, popped = 0, arrived = 0;
    int issue_cyc[$];
    bit prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    int obs_issue = 0, obs_pop = 0;

    always @(negedge CLK) begin
        bit exp_valid, pop_m, exp_issue, exp_done, busy_nx;
        logic [AW-1:0] ai;
        if (reset) begin
            run_m = 0; zero_m = 0; busy_m = 0;
            issued = 0; popped = 0; arrived = 0;
            issue_cyc.delete();
            prev_hold = 0; obs_issue = 0; obs_pop = 0;
        end else begin
            while (issue_cyc.size() > 0 && issue_cyc[0] <= cyc - 2) begin
                void'(issue_cyc.pop_front());
                arrived++;
            end
            exp_valid = (arrived > popped);
            pop_m = exp_valid && out_ready;
            exp_issue = run_m && (issued < len_m) && ((issued - popped - int'(pop_m)) < 2);
            exp_done = zero_m || (run_m && pop_m && (popped == len_m - 1));

            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("sram_cen", 64'(sram_cen), 64'(!exp_issue));
            chk("sram_wen", 64'(sram_wen), 64'd1);
            chk("busy", 64'(busy), 64'(busy_m));
            chk("done", 64'(done), 64'(exp_done));
            if (exp_issue) begin
                ai = AW'(base_m + issued);
                chk("sram_a", 64'(sram_a), 64'(ai));
            end
            if (pop_m) begin
                ai = AW'(base_m + popped);
                chk("out_data", 64'(out_data), 64'(mem[ai]));
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
            end
            obs_issue += int'(!sram_cen);
            obs_pop += int'(out_valid && out_ready);
            if (obs_issue - obs_pop > 2) chk("occupancy_le_2", 64'(obs_issue - obs_pop), 64'd2);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;

            if (exp_issue) begin issued++; issue_cyc.push_back(cyc); end
            if (pop_m) popped++;
            busy_nx = busy_m;
            if (exp_done) begin run_m = 0; zero_m = 0; busy_nx = 0; end
            if (!busy_m && start) begin
                base_m = int'(base_addr);
                len_m = int'(len);
                issued = 0; popped = 0; arrived = 0;
                issue_cyc.delete();
                if (len_m == 0) zero_m = 1; else run_m = 1;
                busy_nx = 1;
            end
            busy_m = busy_nx;
        end
        cyc++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input int b, input int l);
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 10000) begin step(); n++; end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i + 'h100);
        step(); step();
        @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cen", 64'(sram_cen), 64'd1);
        chk("rst_wen", 64'(sram_wen), 64'd1);
        chk("rst_a", 64'(sram_a), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Basic: base 5, len 4, ready held high
        ready_mode = 0;
        start_job(5, 4);
        @(negedge CLK);
        chk("basic_c1_cen", 64'(sram_cen), 64'd0);
        chk("basic_c1_a", 64'(sram_a), 64'd5);
        step(); step();
        @(negedge CLK);
        chk("basic_c3_valid", 64'(out_valid), 64'd1);
        chk("basic_c3_data", 64'(out_data), 64'h105);
        step(); step(); step();
        @(negedge CLK);
        chk("basic_c6_data", 64'(out_data), 64'h108);
        chk("basic_c6_done", 64'(done), 64'd1);
        step();
        @(negedge CLK);
        chk("basic_c7_busy", 64'(busy), 64'd0);
        step();

        // Backpressure with the fixed ready pattern, plus an ignored start mid-run
        ready_mode = 1; pidx = 0;
        start_job(5, 4);
        wait_idle();
        start_job(100, 9);
        step();
        start_job(7, 3);
        wait_idle();

        // Wrap past the top of the address space
        ready_mode = 0;
        start_job(2046, 4);
        wait_idle();

        // Zero length
        start_job(3, 0);
        @(negedge CLK);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_cen", 64'(sram_cen), 64'd1);
        step();
        step();

        // Reset after three beats, then a fresh basic job
        start_job(20, 10);
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge CLK);
        chk("rmid_valid", 64'(out_valid), 64'd0);
        chk("rmid_cen", 64'(sram_cen), 64'd1);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_done", 64'(done), 64'd0);
        step();
        start_job(5, 4);
        wait_idle();

        // Random jobs over random contents
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
        ready_mode = 2;
        for (int j = 0; j < 8; j++) begin
            start_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
            wait_idle();
        end

        // Full sweep of every word
        start_job(0, DEPTH);
        wait_idle();
        start_job(1500, DEPTH);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
